// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: controller state encoding,
// requester identifiers and a small round-robin helper.
package mem_arbiter_pkg;

  // Controller states; IDLE and WAIT may last several cycles, the rest one.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_e;

  // Requester identifiers: A is the interpreter, B is the loader/debug port.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // The requester that is not the given one.
  function automatic logic rr_other(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic winner_o,
  output logic valid_o
);

  // Pick the winner from the current requests and the last grant.
  always_comb begin
    winner_o = REQ_A;
    valid_o  = req_a_i | req_b_i;
    if (req_a_i && req_b_i) begin
      winner_o = rr_other(last_i);
    end else if (req_a_i) begin
      winner_o = REQ_A;
    end else if (req_b_i) begin
      winner_o = REQ_B;
    end else begin
      winner_o = REQ_A;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters (A = interpreter, B = loader/debug) onto a single
// memory adaptor. One access is outstanding at a time; the winner's fields
// are latched at grant so the requester may change them afterwards.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int logsize = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_req,
  input  logic [logsize-1:0] a_addr,
  input  logic [7:0]         a_wdata,
  input  logic               a_wselect,
  output logic               a_ack,
  output logic [7:0]         a_rdata,
  input  logic               b_req,
  input  logic [logsize-1:0] b_addr,
  input  logic [7:0]         b_wdata,
  input  logic               b_wselect,
  output logic               b_ack,
  output logic [7:0]         b_rdata,
  output logic [logsize-1:0] mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               mem_wselect,
  output logic               mem_doit,
  input  logic               mem_busy,
  input  logic               mem_rvalid,
  input  logic [7:0]         mem_rdata
);

  arb_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [logsize-1:0] addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               wsel_q, wsel_d;
  logic [7:0]         pend_q, pend_d;
  logic               seen_q, seen_d;
  logic [7:0]         a_rdata_q, a_rdata_d;
  logic [7:0]         b_rdata_q, b_rdata_d;
  logic               doit_q, doit_d;
  logic               a_ack_q, a_ack_d;
  logic               b_ack_q, b_ack_d;

  logic               pick_winner_s;
  logic               pick_valid_s;
  logic               capture_s;

  rr_pick2 u_rr_pick2 (
    .req_a_i  (a_req),
    .req_b_i  (b_req),
    .last_i   (last_q),
    .winner_o (pick_winner_s),
    .valid_o  (pick_valid_s)
  );

  // Read data is only accepted while a read is in flight at the adaptor.
  assign capture_s = ((state_q == ST_ISSUE) || (state_q == ST_SETTLE) ||
                      (state_q == ST_WAIT)) && !wsel_q && mem_rvalid;

  // Next-state, grant latching, read capture and registered output strobes.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wsel_d    = wsel_q;
    pend_d    = pend_q;
    seen_d    = seen_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    if (capture_s) begin
      pend_d = mem_rdata;
      seen_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!mem_busy && pick_valid_s) begin
          owner_d = pick_winner_s;
          last_d  = pick_winner_s;
          seen_d  = 1'b0;
          if (pick_winner_s == REQ_A) begin
            addr_d  = a_addr;
            wdata_d = a_wdata;
            wsel_d  = a_wselect;
          end else begin
            addr_d  = b_addr;
            wdata_d = b_wdata;
            wsel_d  = b_wselect;
          end
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_SETTLE;
      end
      // The adaptor raises busy one cycle after the strobe, so busy is not
      // trusted here.
      ST_SETTLE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_busy && (wsel_q || seen_q)) begin
          state_d = ST_DONE;
          if (!wsel_q) begin
            if (owner_q == REQ_A) begin
              a_rdata_d = pend_q;
            end else begin
              b_rdata_d = pend_q;
            end
          end else begin
            a_rdata_d = a_rdata_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    doit_d  = (state_d == ST_ISSUE);
    a_ack_d = (state_d == ST_DONE) && (owner_q == REQ_A);
    b_ack_d = (state_d == ST_DONE) && (owner_q == REQ_B);
  end

  // State and datapath registers with synchronous reset; a reset mid-access
  // drops the access without an acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_A;
      last_q    <= REQ_B;
      addr_q    <= {logsize{1'b0}};
      wdata_q   <= 8'h00;
      wsel_q    <= 1'b0;
      pend_q    <= 8'h00;
      seen_q    <= 1'b0;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
      doit_q    <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wsel_q    <= wsel_d;
      pend_q    <= pend_d;
      seen_q    <= seen_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      doit_q    <= doit_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wselect = wsel_q;
  assign mem_doit    = doit_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural adaptor.
module tb_mem_arbiter;

  localparam int   LS        = 4;
  localparam int   INIT_BUSY = 12;
  localparam logic ID_A      = 1'b0;
  localparam logic ID_B      = 1'b1;

  logic          clk;
  logic          reset;
  logic          a_req, b_req, a_wselect, b_wselect, a_ack, b_ack;
  logic [LS-1:0] a_addr, b_addr, mem_addr;
  logic [7:0]    a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          mem_wselect, mem_doit, mem_busy, mem_rvalid;

  mem_arbiter #(.logsize(LS)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wselect(a_wselect),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wselect(b_wselect),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wselect(mem_wselect),
    .mem_doit(mem_doit), .mem_busy(mem_busy), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          wr;
    logic [LS-1:0] addr;
    logic [7:0]    data;
  } op_t;

  typedef struct {
    logic          who;
    logic          wr;
    logic [LS-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
  } exp_t;

  exp_t       sb_q[$];
  op_t        a_ops[$];
  op_t        b_ops[$];
  logic [7:0] model_mem [16];
  logic [7:0] adp_mem [16];
  logic       model_last;
  logic [7:0] exp_a_held, exp_b_held;
  int         n_checks, n_fail;
  int         cyc;
  int         force_k, force_r, cur_k;
  int         init_end_cyc, first_doit_cyc, doit_cyc, exp_lat;
  bit         outstanding, mon_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic op_t mk(input logic wr, input int addr, input int data);
    op_t o;
    o.wr   = wr;
    o.addr = LS'(addr);
    o.data = 8'(data);
    return o;
  endfunction

  // Reference: serve pending operation lists round-robin, one access at a time.
  task automatic plan_round();
    op_t  qa[$];
    op_t  qb[$];
    op_t  o;
    exp_t e;
    logic who;
    qa = a_ops;
    qb = b_ops;
    while (qa.size() > 0 || qb.size() > 0) begin
      if (qa.size() > 0 && qb.size() > 0) who = (model_last == ID_B) ? ID_A : ID_B;
      else if (qa.size() > 0) who = ID_A;
      else who = ID_B;
      if (who == ID_A) o = qa.pop_front();
      else o = qb.pop_front();
      e.who   = who;
      e.wr    = o.wr;
      e.addr  = o.addr;
      e.wdata = o.data;
      e.rdata = o.wr ? 8'h00 : model_mem[o.addr];
      if (o.wr) model_mem[o.addr] = o.data;
      sb_q.push_back(e);
      model_last = who;
    end
  endtask

  task automatic load_a();
    op_t o;
    o = a_ops.pop_front();
    a_addr = o.addr; a_wdata = o.data; a_wselect = o.wr; a_req = 1'b1;
  endtask

  task automatic load_b();
    op_t o;
    o = b_ops.pop_front();
    b_addr = o.addr; b_wdata = o.data; b_wselect = o.wr; b_req = 1'b1;
  endtask

  // Drive one round of queued operations until every access is acknowledged.
  task automatic run_round();
    int total, acks, t;
    total = a_ops.size() + b_ops.size();
    plan_round();
    if (a_ops.size() > 0) load_a();
    if (b_ops.size() > 0) load_b();
    acks = 0;
    t = 0;
    while (acks < total && t < 3000) begin
      @(posedge clk); #1;
      t++;
      if (mem_doit && sb_q.size() > 0) begin
        if (sb_q[0].who == ID_A) begin
          a_addr = LS'($urandom); a_wdata = 8'($urandom); a_wselect = 1'($urandom_range(0, 1));
          if (a_ops.size() == 0 && $urandom_range(0, 1) == 1) a_req = 1'b0;
        end else begin
          b_addr = LS'($urandom); b_wdata = 8'($urandom); b_wselect = 1'($urandom_range(0, 1));
          if (b_ops.size() == 0 && $urandom_range(0, 1) == 1) b_req = 1'b0;
        end
      end
      if (a_ack) begin
        acks++;
        if (a_ops.size() > 0) load_a(); else a_req = 1'b0;
      end
      if (b_ack) begin
        acks++;
        if (b_ops.size() > 0) load_b(); else b_req = 1'b0;
      end
    end
    if (acks < total) fail_now("round_timeout");
    a_req = 1'b0;
    b_req = 1'b0;
    a_ops.delete();
    b_ops.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural adaptor: init busy, then per command busy k cycles, read data
  // on one of those cycles, stray rvalid pulses whenever they must be ignored.
  initial begin
    int k, r;
    logic [LS-1:0] ad;
    logic wr;
    mem_busy = 1'b1; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    repeat (INIT_BUSY) @(posedge clk);
    #1;
    mem_busy = 1'b0;
    init_end_cyc = cyc;
    forever begin
      @(posedge clk); #1;
      if (mem_doit) begin
        mem_rvalid = 1'b0;
        k = (force_k != 0) ? force_k : $urandom_range(1, 4);
        r = (force_r != 0) ? force_r : $urandom_range(1, k);
        cur_k = k;
        ad = mem_addr;
        wr = mem_wselect;
        if (wr) adp_mem[ad] = mem_wdata;
        for (int i = 1; i <= k; i++) begin
          @(posedge clk); #1;
          mem_busy = 1'b1;
          if (!wr) begin
            mem_rvalid = (i == r);
            mem_rdata  = (i == r) ? adp_mem[ad] : 8'($urandom);
          end else begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = 8'($urandom);
          end
        end
        @(posedge clk); #1;
        mem_busy = 1'b0;
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = ($urandom_range(0, 3) == 0);
        mem_rdata  = 8'($urandom);
      end
    end
  end

  // Monitor: compare each command strobe and acknowledge against the scoreboard.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (mem_doit) begin
        check_eq("doit_while_busy", 64'(mem_busy), 64'd0);
        check_eq("doit_single_outstanding", 64'(outstanding), 64'd0);
        if (sb_q.size() == 0) begin
          fail_now("doit_unexpected");
        end else begin
          check_eq("mem_addr", 64'(mem_addr), 64'(sb_q[0].addr));
          check_eq("mem_wselect", 64'(mem_wselect), 64'(sb_q[0].wr));
          check_eq("mem_wdata", 64'(mem_wdata), 64'(sb_q[0].wdata));
        end
        outstanding = 1'b1;
        doit_cyc = cyc;
        exp_lat = cur_k + 2;
        if (first_doit_cyc < 0) first_doit_cyc = cyc;
      end
      if (a_ack || b_ack) begin
        check_eq("ack_both", 64'(a_ack & b_ack), 64'd0);
        if (sb_q.size() == 0) begin
          fail_now("ack_unexpected");
        end else begin
          e = sb_q.pop_front();
          check_eq("ack_owner", 64'(b_ack), 64'(e.who));
          check_eq("ack_latency", 64'(cyc - doit_cyc), 64'(exp_lat));
          if (!e.wr) begin
            if (e.who == ID_A) exp_a_held = e.rdata;
            else exp_b_held = e.rdata;
          end
        end
        outstanding = 1'b0;
      end
      check_eq("a_rdata_hold", 64'(a_rdata), 64'(exp_a_held));
      check_eq("b_rdata_hold", 64'(b_rdata), 64'(exp_b_held));
    end
  end

  // Stimulus: directed scenarios followed by randomized rounds.
  initial begin
    int t, acks, m, n;
    logic [7:0] v;
    n_checks = 0; n_fail = 0; mon_en = 1'b0; outstanding = 1'b0;
    force_k = 0; force_r = 0; cur_k = 1; first_doit_cyc = -1; init_end_cyc = 0;
    doit_cyc = 0; exp_lat = 0;
    model_last = ID_B; exp_a_held = 8'h00; exp_b_held = 8'h00;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      model_mem[i] = v;
      adp_mem[i]   = v;
    end
    reset = 1'b1;
    a_req = 1'b0; a_addr = '0; a_wdata = 8'h00; a_wselect = 1'b0;
    b_req = 1'b0; b_addr = '0; b_wdata = 8'h00; b_wselect = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("reset_doit", 64'(mem_doit), 64'd0);
    check_eq("reset_a_ack", 64'(a_ack), 64'd0);
    check_eq("reset_b_ack", 64'(b_ack), 64'd0);
    check_eq("reset_a_rdata", 64'(a_rdata), 64'd0);
    check_eq("reset_b_rdata", 64'(b_rdata), 64'd0);
    mon_en = 1'b1;

    // Both request during adaptor init: nothing issued until busy drops, A first.
    a_ops.push_back(mk(1'b1, 5, 8'h11));
    b_ops.push_back(mk(1'b1, 6, 8'h22));
    run_round();
    check_eq("first_doit_after_init", 64'(first_doit_cyc > init_end_cyc), 64'd1);

    // B writes 0x5A to address 3 with a one-cycle adaptor.
    force_k = 1;
    b_ops.push_back(mk(1'b1, 3, 8'h5A));
    run_round();

    // A reads it back with read data arriving during SETTLE.
    force_k = 1; force_r = 1;
    a_ops.push_back(mk(1'b0, 3, 0));
    run_round();
    check_eq("a_read_5a", 64'(a_rdata), 64'h5A);

    force_k = 2; force_r = 2;
    b_ops.push_back(mk(1'b0, 3, 0));
    run_round();

    // Long busy after the strobe.
    force_k = 50; force_r = 0;
    a_ops.push_back(mk(1'b1, 9, 8'hC3));
    run_round();

    // Reset in WAIT of a read aborts it without acknowledge.
    force_k = 20;
    a_ops.push_back(mk(1'b0, 5, 0));
    plan_round();
    load_a();
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!mem_doit && t < 200);
    if (!mem_doit) fail_now("reset_test_no_doit");
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    a_req = 1'b0;
    a_ops.delete();
    sb_q.delete();
    outstanding = 1'b0;
    exp_a_held = 8'h00;
    exp_b_held = 8'h00;
    model_last = ID_B;
    force_k = 0; force_r = 0;
    check_eq("midreset_a_rdata", 64'(a_rdata), 64'd0);
    check_eq("midreset_b_rdata", 64'(b_rdata), 64'd0);
    check_eq("midreset_doit", 64'(mem_doit), 64'd0);
    acks = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) acks++;
    end
    check_eq("midreset_no_ack", 64'(acks), 64'd0);

    // Normal service after the aborted access; tie goes to A again.
    a_ops.push_back(mk(1'b0, 6, 0));
    b_ops.push_back(mk(1'b0, 5, 0));
    run_round();
    check_eq("post_reset_b_read", 64'(b_rdata), 64'h11);

    // Randomized rounds, including requesters holding req for back-to-back ops.
    for (int rnd = 0; rnd < 60; rnd++) begin
      m = $urandom_range(1, 3);
      if (m != 2) begin
        n = $urandom_range(1, 2);
        for (int j = 0; j < n; j++)
          a_ops.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255)));
      end
      if (m != 1) begin
        n = $urandom_range(1, 2);
        for (int j = 0; j < n; j++)
          b_ops.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255)));
      end
      run_round();
    end
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
